// File: rtl/nvdla_dbb_axi_sram_slave_if.sv
// nvdla_dbb_axi_sram_slave_if
// Groups the NVDLA DBB AXI4 channels (64-bit data, 32-bit address,
// 6-bit ID, 8-bit LEN) that run between the core's dbb master port and
// the SRAM-backed responder.
//   AW : awvalid/awready handshake, awid, awaddr, awlen, awsize, awburst
//   W  : wvalid/wready handshake, wdata, wstrb, wlast
//   B  : bvalid/bready handshake, bid, bresp, buser
//   AR : arvalid/arready handshake, arid, araddr, arlen, arsize, arburst
//   R  : rvalid/rready handshake, rid, rdata, rresp, rlast, ruser
// Modports: master (drives requests) and slave (drives responses).
interface nvdla_dbb_axi_sram_slave_if;
    logic        dbb_aw_awvalid;
    logic        dbb_aw_awready;
    logic [5:0]  dbb_aw_awid;
    logic [31:0] dbb_aw_awaddr;
    logic [7:0]  dbb_aw_awlen;
    logic [2:0]  dbb_aw_awsize;
    logic [1:0]  dbb_aw_awburst;

    logic        dbb_w_wvalid;
    logic        dbb_w_wready;
    logic [63:0] dbb_w_wdata;
    logic [7:0]  dbb_w_wstrb;
    logic        dbb_w_wlast;

    logic        dbb_b_bvalid;
    logic        dbb_b_bready;
    logic [5:0]  dbb_b_bid;
    logic [1:0]  dbb_b_bresp;
    logic        dbb_b_buser;

    logic        dbb_ar_arvalid;
    logic        dbb_ar_arready;
    logic [5:0]  dbb_ar_arid;
    logic [31:0] dbb_ar_araddr;
    logic [7:0]  dbb_ar_arlen;
    logic [2:0]  dbb_ar_arsize;
    logic [1:0]  dbb_ar_arburst;

    logic        dbb_r_rvalid;
    logic        dbb_r_rready;
    logic [5:0]  dbb_r_rid;
    logic [63:0] dbb_r_rdata;
    logic [1:0]  dbb_r_rresp;
    logic        dbb_r_rlast;
    logic        dbb_r_ruser;

    modport slave (
        input  dbb_aw_awvalid, dbb_aw_awid, dbb_aw_awaddr, dbb_aw_awlen, dbb_aw_awsize, dbb_aw_awburst,
        output dbb_aw_awready,
        input  dbb_w_wvalid, dbb_w_wdata, dbb_w_wstrb, dbb_w_wlast,
        output dbb_w_wready,
        output dbb_b_bvalid, dbb_b_bid, dbb_b_bresp, dbb_b_buser,
        input  dbb_b_bready,
        input  dbb_ar_arvalid, dbb_ar_arid, dbb_ar_araddr, dbb_ar_arlen, dbb_ar_arsize, dbb_ar_arburst,
        output dbb_ar_arready,
        output dbb_r_rvalid, dbb_r_rid, dbb_r_rdata, dbb_r_rresp, dbb_r_rlast, dbb_r_ruser,
        input  dbb_r_rready
    );

    modport master (
        output dbb_aw_awvalid, dbb_aw_awid, dbb_aw_awaddr, dbb_aw_awlen, dbb_aw_awsize, dbb_aw_awburst,
        input  dbb_aw_awready,
        output dbb_w_wvalid, dbb_w_wdata, dbb_w_wstrb, dbb_w_wlast,
        input  dbb_w_wready,
        input  dbb_b_bvalid, dbb_b_bid, dbb_b_bresp, dbb_b_buser,
        output dbb_b_bready,
        output dbb_ar_arvalid, dbb_ar_arid, dbb_ar_araddr, dbb_ar_arlen, dbb_ar_arsize, dbb_ar_arburst,
        input  dbb_ar_arready,
        input  dbb_r_rvalid, dbb_r_rid, dbb_r_rdata, dbb_r_rresp, dbb_r_rlast, dbb_r_ruser,
        output dbb_r_rready
    );
endinterface

// File: rtl/nvdla_dbb_axi_sram_slave.sv
// nvdla_dbb_axi_sram_slave
// AXI4 responder terminating the NVDLA DBB master port with an internal
// 2^MEM_AW x 64-bit word-addressed SRAM model (replaces DRAM for bring-up).
// Write and read channels are independent; each takes one burst at a time.
// Ports:
//   dla_core_clk   - the only clock, rising edge
//   dla_reset_rstn - asynchronous active-low reset (memory is not reset)
//   dbb            - slave modport carrying the AW/W/B/AR/R channels
module nvdla_dbb_axi_sram_slave #(
    parameter int MEM_AW = 12
) (
    input  logic                             dla_core_clk,
    input  logic                             dla_reset_rstn,
    nvdla_dbb_axi_sram_slave_if.slave        dbb
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA} r_state_e;

    localparam logic [2:0] SIZE_64    = 3'b011;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_SLV   = 2'b10;

    logic [63:0] mem [2**MEM_AW];

    w_state_e          w_state_q, w_state_d;
    logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [5:0]        w_id_q, w_id_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [MEM_AW-1:0] w_idx_q, w_idx_d, aw_idx;
    logic [7:0]        w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic              w_bad_q, w_bad_d, w_err_q, w_err_d;
    logic              mem_we, aw_hs, w_hs, b_hs, w_final;

    r_state_e          r_state_q, r_state_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic              r_bad_q, r_bad_d, ar_bad, ar_hs, r_hs;
    logic [63:0]       rdata_q, rdata_d, rd_word;
    logic [1:0]        rresp_q, rresp_d;
    logic [5:0]        r_id_q, r_id_d;
    logic [MEM_AW-1:0] r_idx_q, r_idx_d, ar_idx, rd_idx;
    logic [7:0]        r_len_q, r_len_d, r_cnt_q, r_cnt_d;

    // Address bits outside the word index alias and are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{dbb.dbb_aw_awaddr[31:MEM_AW+3], dbb.dbb_aw_awaddr[2:0],
                                dbb.dbb_ar_araddr[31:MEM_AW+3], dbb.dbb_ar_araddr[2:0]};

    assign aw_idx  = dbb.dbb_aw_awaddr[MEM_AW+2:3];
    assign ar_idx  = dbb.dbb_ar_araddr[MEM_AW+2:3];
    assign aw_hs   = dbb.dbb_aw_awvalid & awready_q;
    assign w_hs    = dbb.dbb_w_wvalid & wready_q;
    assign b_hs    = bvalid_q & dbb.dbb_b_bready;
    assign ar_hs   = dbb.dbb_ar_arvalid & arready_q;
    assign r_hs    = rvalid_q & dbb.dbb_r_rready;
    assign w_final = (w_cnt_q == w_len_q);
    assign ar_bad  = (dbb.dbb_ar_arsize != SIZE_64) || (dbb.dbb_ar_arburst != BURST_INCR);

    // The first beat is fetched from the AR address, later beats from the
    // running index. The fetch reads the array before this edge's write
    // lands, so a same-cycle collision returns the old word.
    assign rd_idx  = (r_state_q == R_IDLE) ? ar_idx : r_idx_q;
    assign rd_word = mem[rd_idx];

    assign dbb.dbb_aw_awready = awready_q;
    assign dbb.dbb_w_wready   = wready_q;
    assign dbb.dbb_b_bvalid   = bvalid_q;
    assign dbb.dbb_b_bid      = w_id_q;
    assign dbb.dbb_b_bresp    = bresp_q;
    assign dbb.dbb_b_buser    = 1'b0;
    assign dbb.dbb_ar_arready = arready_q;
    assign dbb.dbb_r_rvalid   = rvalid_q;
    assign dbb.dbb_r_rid      = r_id_q;
    assign dbb.dbb_r_rdata    = rdata_q;
    assign dbb.dbb_r_rresp    = rresp_q;
    assign dbb.dbb_r_rlast    = rlast_q;
    assign dbb.dbb_r_ruser    = 1'b0;

    // Byte-masked SRAM write; no reset so contents survive a mid-burst reset.
    always_ff @(posedge dla_core_clk) begin
        if (mem_we) begin
            for (int k = 0; k < 8; k++) begin
                if (dbb.dbb_w_wstrb[k]) mem[w_idx_q][8*k +: 8] <= dbb.dbb_w_wdata[8*k +: 8];
            end
        end
    end

    // Write FSM. The burst ends on beat count; wlast only feeds the error flag.
    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        w_id_d    = w_id_q;
        bresp_d   = bresp_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_bad_d   = w_bad_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (aw_hs) begin
                    w_state_d = W_DATA;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_id_d    = dbb.dbb_aw_awid;
                    w_idx_d   = aw_idx;
                    w_len_d   = dbb.dbb_aw_awlen;
                    w_cnt_d   = 8'd0;
                    w_bad_d   = (dbb.dbb_aw_awsize != SIZE_64) || (dbb.dbb_aw_awburst != BURST_INCR);
                    w_err_d   = 1'b0;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    mem_we  = !w_bad_q;
                    w_idx_d = w_idx_q + 1'b1;
                    w_cnt_d = w_cnt_q + 1'b1;
                    if (w_final) begin
                        w_state_d = W_RESP;
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = (w_bad_q || w_err_q || !dbb.dbb_w_wlast) ? RESP_SLV : RESP_OKAY;
                    end else if (dbb.dbb_w_wlast) begin
                        w_err_d = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read FSM. rdata is prefetched one beat ahead and held while stalled.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_bad_d   = r_bad_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rlast_d   = (dbb.dbb_ar_arlen == 8'd0);
                    rdata_d   = ar_bad ? 64'd0 : rd_word;
                    rresp_d   = ar_bad ? RESP_SLV : RESP_OKAY;
                    r_id_d    = dbb.dbb_ar_arid;
                    r_idx_d   = ar_idx + 1'b1;
                    r_len_d   = dbb.dbb_ar_arlen;
                    r_cnt_d   = 8'd0;
                    r_bad_d   = ar_bad;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                    end else begin
                        rdata_d = r_bad_q ? 64'd0 : rd_word;
                        r_idx_d = r_idx_q + 1'b1;
                        r_cnt_d = r_cnt_q + 1'b1;
                        rlast_d = ((r_cnt_q + 1'b1) == r_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge dla_core_clk or negedge dla_reset_rstn) begin
        if (!dla_reset_rstn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            w_id_q    <= '0;
            bresp_q   <= '0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_bad_q   <= 1'b0;
            w_err_q   <= 1'b0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_bad_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            w_id_q    <= w_id_d;
            bresp_q   <= bresp_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_bad_q   <= w_bad_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_bad_q   <= r_bad_d;
        end
    end
endmodule

// File: doc/nvdla_dbb_axi_sram_slave.md
# nvdla_dbb_axi_sram_slave

AXI4 responder that terminates the NVDLA DBB master port (64-bit data, 32-bit address, 6-bit ID, 8-bit LEN) with an internal word-addressed SRAM model. It is the far end of the core's dbb interface in FPGA and simulation builds, and replaces external DRAM for bring-up and regression. The write and read channels are independent, and each channel accepts one outstanding burst at a time.

## Interface
- MEM_AW, default 12: log2 of the memory depth in 64-bit words. The memory is 4096 × 64 by default.
- dla_core_clk, in, 1: the only clock. All logic is rising-edge.
- dla_reset_rstn, in, 1: reset. It is asynchronous and active-low.
- dbb_aw_awvalid, in, 1 / dbb_aw_awready, out, 1: write address handshake.
- dbb_aw_awid, in, 6; dbb_aw_awaddr, in, 32; dbb_aw_awlen, in, 8; dbb_aw_awsize, in, 3; dbb_aw_awburst, in, 2: write address fields.
- dbb_w_wvalid, in, 1 / dbb_w_wready, out, 1; dbb_w_wdata, in, 64; dbb_w_wstrb, in, 8; dbb_w_wlast, in, 1: write data channel.
- dbb_b_bvalid, out, 1 / dbb_b_bready, in, 1; dbb_b_bid, out, 6; dbb_b_bresp, out, 2; dbb_b_buser, out, 1: write response channel. buser is tied to 0.
- dbb_ar_arvalid, in, 1 / dbb_ar_arready, out, 1; dbb_ar_arid, in, 6; dbb_ar_araddr, in, 32; dbb_ar_arlen, in, 8; dbb_ar_arsize, in, 3; dbb_ar_arburst, in, 2: read address channel.
- dbb_r_rvalid, out, 1 / dbb_r_rready, in, 1; dbb_r_rid, out, 6; dbb_r_rdata, out, 64; dbb_r_rresp, out, 2; dbb_r_rlast, out, 1; dbb_r_ruser, out, 1: read data channel. ruser is tied to 0.
- Sideband inputs are ignored: lock, cache, prot, qos, awuser, aruser, wuser.

## Operation
- **Word index:** addr[MEM_AW+2:3]. Bits [2:0] are ignored. Upper bits alias, so there is no decode error.
- **Burst advance:** the index increments by 1 per beat and wraps modulo 2^MEM_AW.
- **Legal bursts:** size = 3'b011 and burst = 2'b01 (INCR). Any other combination is flagged bad.
  - A bad write burst is still fully accepted, but memory is not modified and bresp = 2'b10 (SLVERR).
  - A bad read burst returns rdata = 0 with rresp = 2'b10 on every beat.
- **Memory:** not reset. Byte lane k is written only when wstrb[k] = 1.

Write FSM:
- **W_IDLE:** awready = 1. On AW handshake, capture id, index, len and the bad flag, clear the beat counter, and go to W_DATA.
- **W_DATA:** wready = 1. On each W handshake, perform the masked write and increment the counter.
  - After beat len+1, go to W_RESP.
  - Termination is by count; wlast does not end the burst.
  - If wlast is not asserted on the final beat, or is asserted on an earlier beat, set err, which forces bresp = 2'b10.
- **W_RESP:** bvalid = 1, bid = captured id, bresp = 2'b00 unless the burst was bad or err is set. On B handshake, go to W_IDLE.

Read FSM:
- **R_IDLE:** arready = 1. On AR handshake, capture id, len and the bad flag, register rdata <= mem[index], and go to R_DATA.
- **R_DATA:** rvalid = 1, rid = captured id, rlast = (beat == len).
  - On an R handshake that is not last, register the next word into rdata and stay in R_DATA.
  - On the last handshake, go to R_IDLE.
  - While rready = 0, rdata, rlast and rvalid hold stable.
- **Read/write collision:** a read fetch and a write to the same word in the same cycle returns the old data. The new data is visible to any fetch in a later cycle.

## Timing
- **Reset values:** all valid outputs are 0; awready = 0; arready = 0; bresp = 0; rresp = 0; rdata = 0; rlast = 0; bid = 0; rid = 0. Both FSMs reset to IDLE.
- **Ready after reset:** awready and arready are registered. They go to 1 on the first clock edge after reset release and drop to 0 in the cycle after a handshake.
- **All outputs are registered.** There are no combinational input-to-output paths.
- **Write latency:**
  - W beats are accepted from the cycle after the AW handshake, one per cycle while wvalid = 1.
  - bvalid rises the cycle after the last W handshake.
  - awready returns the cycle after the B handshake.
- **Read latency:**
  - rvalid rises the cycle after the AR handshake.
  - Beats stream at one per cycle while rready = 1.
  - arready returns the cycle after the rlast handshake.
- **W before AW:** wvalid asserted before AW is accepted is not consumed, because wready stays 0.
- **Channel independence:** simultaneous AW and AR handshakes are both accepted in the same cycle.
- **Reset mid-burst:** asynchronous reset aborts any burst. Outputs return to reset values immediately, and memory contents are retained.

## Test plan
- **Single-beat write then read:**
  - Stimulus: AW addr 0x100, len 0, wdata 0x1122334455667788, wstrb 0xFF; then AR 0x100, len 0.
  - Expected: bresp 0, bid echoed; then rdata 0x1122334455667788, rlast = 1 on the first beat, rvalid 1 cycle after AR.
- **Burst with byte strobes:**
  - Stimulus: a len = 7 write of 8 words to 0x200, with beat 3 using wstrb 0x0F; then a len = 7 read.
  - Expected: 8 beats in order; beat 3 upper 4 bytes keep the old value; rlast only on beat 7.
- **Address wrap:**
  - Stimulus: write len = 3 starting at word 4094 (MEM_AW = 12).
  - Expected: the words land at 4094, 4095, 0 and 1.
- **Error cases:**
  - awsize = 3'b010 → memory unchanged, bresp 2'b10.
  - wlast missing on the final beat → bresp 2'b10.
  - arburst = 2'b00 → rdata 0 and rresp 2'b10 on every beat.
- **Backpressure:**
  - Stimulus: rready toggled 1-0-1 during a len = 3 read; bready held low for 5 cycles.
  - Expected: R outputs stable while stalled, no beats lost; bvalid held for the full 5 cycles.
- **Concurrency and reset:**
  - Stimulus: AW and AR issued in the same cycle to the same word.
  - Expected: the read returns the pre-write data.
  - Stimulus: reset asserted mid-read.
  - Expected: rvalid drops immediately; after release arready = 1 and the next read returns the stored data.
